// File: rtl/branch.sv
// Stream splitter: each cond/value pair is routed to the true output when cond
// is nonzero, otherwise to the false output. Cond and value are buffered independently.

module branch_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   input  logic             pop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop_ok;

   // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
   assign in_ready = !rst && (count != FULL);
   assign push     = in_valid && in_ready;
   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   assign head     = mem[rd_ptr];

   // NOTE: the storage array has no reset; only pointers and count are cleared,
   // which is enough to make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

module branch #(
   parameter int VAL_WIDTH  = 16,
   parameter int COND_WIDTH = 1,
   parameter int FIFO_SIZE  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COND_WIDTH-1:0] s_cond_axis_tdata,
   input  logic                  s_cond_axis_tvalid,
   output logic                  s_cond_axis_tready,
   input  logic [VAL_WIDTH-1:0]  s_val_axis_tdata,
   input  logic                  s_val_axis_tvalid,
   output logic                  s_val_axis_tready,
   output logic [VAL_WIDTH-1:0]  m_true_val_axis_tdata,
   output logic                  m_true_val_axis_tvalid,
   input  logic                  m_true_val_axis_tready,
   output logic [VAL_WIDTH-1:0]  m_false_val_axis_tdata,
   output logic                  m_false_val_axis_tvalid,
   input  logic                  m_false_val_axis_tready
);

   logic [COND_WIDTH-1:0] cond_head;
   logic [VAL_WIDTH-1:0]  val_head;
   logic                  cond_empty;
   logic                  val_empty;
   logic                  pair_pop;
   logic                  load_true;
   logic                  load_false;

   branch_fifo #(.WIDTH(COND_WIDTH), .DEPTH(FIFO_SIZE)) u_cond_fifo (
      .clk      (clk),
      .rst      (rst),
      .in_data  (s_cond_axis_tdata),
      .in_valid (s_cond_axis_tvalid),
      .in_ready (s_cond_axis_tready),
      .head     (cond_head),
      .empty    (cond_empty),
      .pop      (pair_pop)
   );

   branch_fifo #(.WIDTH(VAL_WIDTH), .DEPTH(FIFO_SIZE)) u_val_fifo (
      .clk      (clk),
      .rst      (rst),
      .in_data  (s_val_axis_tdata),
      .in_valid (s_val_axis_tvalid),
      .in_ready (s_val_axis_tready),
      .head     (val_head),
      .empty    (val_empty),
      .pop      (pair_pop)
   );

   // Only the head pair is considered: a stalled target blocks everything behind it.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      pair_pop   = 1'b0;
      load_true  = 1'b0;
      load_false = 1'b0;
      if (!cond_empty && !val_empty) begin
         if (|cond_head) begin
            load_true = !m_true_val_axis_tvalid || m_true_val_axis_tready;
         end else begin
            load_false = !m_false_val_axis_tvalid || m_false_val_axis_tready;
         end
         pair_pop = load_true || load_false;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_true_val_axis_tvalid <= 1'b0;
         m_true_val_axis_tdata  <= '0;
      end else if (load_true) begin
         m_true_val_axis_tvalid <= 1'b1;
         m_true_val_axis_tdata  <= val_head;
      end else if (m_true_val_axis_tready) begin
         m_true_val_axis_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_false_val_axis_tvalid <= 1'b0;
         m_false_val_axis_tdata  <= '0;
      end else if (load_false) begin
         m_false_val_axis_tvalid <= 1'b1;
         m_false_val_axis_tdata  <= val_head;
      end else if (m_false_val_axis_tready) begin
         m_false_val_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_branch.sv
// Self-checking bench for branch: directed vector table, multi-cycle corner
// sequences, and a randomized-backpressure phase against an in-order scoreboard.

module tb_branch;

   localparam int VW = 16;
   localparam int CW = 4;
   localparam int FS = 16;
   localparam int NV = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] s_cond_tdata;
   logic          s_cond_tvalid;
   logic          s_cond_tready;
   logic [VW-1:0] s_val_tdata;
   logic          s_val_tvalid;
   logic          s_val_tready;
   logic [VW-1:0] m_true_tdata;
   logic          m_true_tvalid;
   logic          m_true_tready;
   logic [VW-1:0] m_false_tdata;
   logic          m_false_tvalid;
   logic          m_false_tready;

   always #5 clk = ~clk;

   branch #(.VAL_WIDTH(VW), .COND_WIDTH(CW), .FIFO_SIZE(FS)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .s_cond_axis_tdata       (s_cond_tdata),
      .s_cond_axis_tvalid      (s_cond_tvalid),
      .s_cond_axis_tready      (s_cond_tready),
      .s_val_axis_tdata        (s_val_tdata),
      .s_val_axis_tvalid       (s_val_tvalid),
      .s_val_axis_tready       (s_val_tready),
      .m_true_val_axis_tdata   (m_true_tdata),
      .m_true_val_axis_tvalid  (m_true_tvalid),
      .m_true_val_axis_tready  (m_true_tready),
      .m_false_val_axis_tdata  (m_false_tdata),
      .m_false_val_axis_tvalid (m_false_tvalid),
      .m_false_val_axis_tready (m_false_tready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: accepted conds/values are paired in arrival order and queued per side.
   logic [CW-1:0] mc_q [$];
   logic [VW-1:0] mv_q [$];
   logic [VW-1:0] exp_t [$];
   logic [VW-1:0] exp_f [$];

   always @(negedge clk) begin : monitor
      logic [CW-1:0] c;
      logic [VW-1:0] v;
      logic [VW-1:0] e;
      if (rst) begin
         mc_q.delete();
         mv_q.delete();
         exp_t.delete();
         exp_f.delete();
      end else begin
         if (m_true_tvalid && m_true_tready) begin
            if (exp_t.size() == 0) check("true_extra_output", exp_t.size(), 1);
            else begin
               e = exp_t.pop_front();
               check("true_order", m_true_tdata, e);
            end
         end
         if (m_false_tvalid && m_false_tready) begin
            if (exp_f.size() == 0) check("false_extra_output", exp_f.size(), 1);
            else begin
               e = exp_f.pop_front();
               check("false_order", m_false_tdata, e);
            end
         end
         if (s_cond_tvalid && s_cond_tready) mc_q.push_back(s_cond_tdata);
         if (s_val_tvalid && s_val_tready)   mv_q.push_back(s_val_tdata);
         while (mc_q.size() > 0 && mv_q.size() > 0) begin
            c = mc_q.pop_front();
            v = mv_q.pop_front();
            if (c != '0) exp_t.push_back(v);
            else         exp_f.push_back(v);
         end
      end
   end

   task automatic drain(input string name);
      int k = 0;
      while ((exp_t.size() + exp_f.size() + mc_q.size() + mv_q.size()) != 0 && k < 300) begin
         @(posedge clk);
         k++;
      end
      repeat (2) @(posedge clk);
      #1;
      check({name, "_pending"}, exp_t.size() + exp_f.size() + mc_q.size() + mv_q.size(), 0);
      check({name, "_true_idle"}, m_true_tvalid, 1'b0);
      check({name, "_false_idle"}, m_false_tvalid, 1'b0);
   endtask

   task automatic push_cond(input logic [CW-1:0] c);
      int k = 0;
      s_cond_tvalid = 1'b1;
      s_cond_tdata  = c;
      @(negedge clk);
      while (!s_cond_tready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("cond_accept", s_cond_tready, 1'b1);
      @(posedge clk);
      #1;
      s_cond_tvalid = 1'b0;
   endtask

   task automatic push_val(input logic [VW-1:0] v);
      int k = 0;
      s_val_tvalid = 1'b1;
      s_val_tdata  = v;
      @(negedge clk);
      while (!s_val_tready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("val_accept", s_val_tready, 1'b1);
      @(posedge clk);
      #1;
      s_val_tvalid = 1'b0;
   endtask

   typedef struct {
      logic [CW-1:0] cond;
      logic [VW-1:0] val;
      logic          to_true;
   } vec_t;

   vec_t vecs [NV];
   bit   c_done;
   bit   v_done;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      s_cond_tdata   = '0;
      s_cond_tvalid  = 1'b0;
      s_val_tdata    = '0;
      s_val_tvalid   = 1'b0;
      m_true_tready  = 1'b1;
      m_false_tready = 1'b1;

      vecs[0] = '{4'h1, 16'h00A1, 1'b1};
      vecs[1] = '{4'h0, 16'h00B2, 1'b0};
      vecs[2] = '{4'h1, 16'h00C3, 1'b1};
      vecs[3] = '{4'h8, 16'h1234, 1'b1};
      vecs[4] = '{4'h0, 16'h5678, 1'b0};
      vecs[5] = '{4'h2, 16'hBEEF, 1'b1};
      vecs[6] = '{4'h4, 16'h0F0F, 1'b1};
      vecs[7] = '{4'h0, 16'hCAFE, 1'b0};
      vecs[8] = '{4'h0, 16'hDEAD, 1'b0};
      vecs[9] = '{4'hF, 16'hFFFF, 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cond_ready", s_cond_tready, 1'b0);
      check("rst_val_ready", s_val_tready, 1'b0);
      check("rst_true_valid", m_true_tvalid, 1'b0);
      check("rst_false_valid", m_false_tvalid, 1'b0);
      check("rst_true_data", m_true_tdata, 16'h0);
      check("rst_false_data", m_false_tdata, 16'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("release_cond_ready", s_cond_tready, 1'b1);
      check("release_val_ready", s_val_tready, 1'b1);

      // Vector table: one pair per cycle, each visible two cycles later with no bubbles
      for (int i = 0; i < NV + 2; i++) begin
         @(posedge clk);
         #1;
         if (i >= 2) begin
            if (vecs[i-2].to_true) begin
               check($sformatf("vec%0d_true_valid", i-2), m_true_tvalid, 1'b1);
               check($sformatf("vec%0d_true_data", i-2), m_true_tdata, vecs[i-2].val);
               check($sformatf("vec%0d_false_quiet", i-2), m_false_tvalid, 1'b0);
            end else begin
               check($sformatf("vec%0d_false_valid", i-2), m_false_tvalid, 1'b1);
               check($sformatf("vec%0d_false_data", i-2), m_false_tdata, vecs[i-2].val);
               check($sformatf("vec%0d_true_quiet", i-2), m_true_tvalid, 1'b0);
            end
         end
         if (i < NV) begin
            s_cond_tvalid = 1'b1;
            s_cond_tdata  = vecs[i].cond;
            s_val_tvalid  = 1'b1;
            s_val_tdata   = vecs[i].val;
         end else begin
            s_cond_tvalid = 1'b0;
            s_val_tvalid  = 1'b0;
         end
      end
      drain("table");

      // Fill the cond FIFO with no values, then release values
      for (int i = 0; i < FS; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("fill%0d_cond_ready", i), s_cond_tready, 1'b1);
         s_cond_tvalid = 1'b1;
         s_cond_tdata  = (i % 2 == 1) ? 4'h0 : ((i % 4 == 0) ? 4'h8 : 4'h1);
      end
      @(posedge clk);
      #1;
      s_cond_tvalid = 1'b0;
      check("full_cond_ready", s_cond_tready, 1'b0);
      check("full_val_ready", s_val_tready, 1'b1);
      @(posedge clk);
      #1;
      check("full_cond_ready_hold", s_cond_tready, 1'b0);
      check("full_no_output", m_true_tvalid | m_false_tvalid, 1'b0);
      for (int i = 0; i < FS; i++) begin
         check($sformatf("fillv%0d_val_ready", i), s_val_tready, 1'b1);
         s_val_tvalid = 1'b1;
         s_val_tdata  = 16'h0100 + 16'(i);
         @(posedge clk);
         #1;
      end
      s_val_tvalid = 1'b0;
      drain("fill");
      check("fill_cond_ready_back", s_cond_tready, 1'b1);

      // Head-of-line stall on the true side
      m_true_tready  = 1'b0;
      m_false_tready = 1'b1;
      @(posedge clk);
      #1;
      s_cond_tvalid = 1'b1; s_cond_tdata = 4'h1; s_val_tvalid = 1'b1; s_val_tdata = 16'h0011;
      @(posedge clk);
      #1;
      s_cond_tdata = 4'h1; s_val_tdata = 16'h0033;
      @(posedge clk);
      #1;
      s_cond_tdata = 4'h0; s_val_tdata = 16'h0022;
      @(posedge clk);
      #1;
      s_cond_tvalid = 1'b0; s_val_tvalid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall%0d_true_valid", j), m_true_tvalid, 1'b1);
         check($sformatf("stall%0d_true_data", j), m_true_tdata, 16'h0011);
         check($sformatf("stall%0d_false_quiet", j), m_false_tvalid, 1'b0);
      end
      m_true_tready = 1'b1;
      drain("stall");

      // Reset in the middle of traffic
      m_true_tready  = 1'b0;
      m_false_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         s_cond_tvalid = 1'b1; s_cond_tdata = (i % 2 == 0) ? 4'h1 : 4'h0;
         s_val_tvalid  = 1'b1; s_val_tdata  = 16'h0200 + 16'(i);
      end
      @(posedge clk);
      #1;
      s_cond_tvalid = 1'b0; s_val_tvalid = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_true_valid", m_true_tvalid, 1'b1);
      check("pre_rst_false_valid", m_false_tvalid, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_cond_ready", s_cond_tready, 1'b0);
      check("mid_rst_val_ready", s_val_tready, 1'b0);
      @(posedge clk);
      #1;
      check("post_rst_true_valid", m_true_tvalid, 1'b0);
      check("post_rst_false_valid", m_false_tvalid, 1'b0);
      check("post_rst_true_data", m_true_tdata, 16'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_true_tready  = 1'b1;
      m_false_tready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(posedge clk);
         #1;
         check($sformatf("after_rst%0d_no_stale", j), {m_true_tvalid, m_false_tvalid}, 2'b00);
      end
      s_cond_tvalid = 1'b1; s_cond_tdata = 4'h0; s_val_tvalid = 1'b1; s_val_tdata = 16'h5A5A;
      @(posedge clk);
      #1;
      s_cond_tvalid = 1'b0; s_val_tvalid = 1'b0;
      drain("after_rst");

      // Independent producers with random backpressure
      c_done = 1'b0;
      v_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               int gap;
               push_cond(CW'($urandom_range(0, 15)));
               gap = $urandom_range(0, 2);
               repeat (gap) begin @(posedge clk); #1; end
            end
            c_done = 1'b1;
         end
         begin
            for (int n = 0; n < 40; n++) begin
               int gap;
               push_val(VW'($urandom_range(0, 65535)));
               gap = $urandom_range(0, 3);
               repeat (gap) begin @(posedge clk); #1; end
            end
            v_done = 1'b1;
         end
         begin
            while (!(c_done && v_done)) begin
               @(posedge clk);
               #1;
               m_true_tready  = 1'($urandom_range(0, 1));
               m_false_tready = 1'($urandom_range(0, 1));
            end
         end
      join
      m_true_tready  = 1'b1;
      m_false_tready = 1'b1;
      drain("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
